mux4a1_serializer: RTL and testbench

Transmit-side counterpart of the two-level byte demultiplexer. It accepts a group of four parallel byte lanes, each with its own valid, and re-serializes them onto a single byte lane at one byte per `cclk` cycle, in lane order 0,1,2,3. It sits in front of the demux chain in loop-back benches and in the transmit path, so that demux output can be compared against original stimulus.

---
 rtl/mux4a1_serializer_pkg.sv | 15 +
 rtl/lane_pick4.sv | 30 +++
 rtl/mux4a1_serializer.sv | 150 +++++++++++++++
 tb/tb_mux4a1_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4a1_serializer_pkg.sv
// mux4a1_serializer_pkg
//   Shared definitions for the 4-lane byte serializer: FSM state encoding,
//   lane count and default data-lane width.
//   Optional feature macro: MUX_SKIP_INVALID_EN (see mux4a1_serializer.sv).
package mux4a1_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int unsigned LANES      = 4;
    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/lane_pick4.sv
// lane_pick4
//   Combinational next-valid-lane finder: returns the lowest lane index
//   >= i_start whose bit is set in i_mask.
//   Ports:
//     i_mask   [3:0]  per-lane valid mask
//     i_start  [1:0]  first lane index eligible for selection
//     o_idx    [1:0]  selected lane (0 when nothing found)
//     o_found         a lane was found
//   Only instantiated when MUX_SKIP_INVALID_EN is defined.
module lane_pick4
    import mux4a1_serializer_pkg::*;
(
    input  logic [3:0] i_mask,
    input  logic [1:0] i_start,
    output logic [1:0] o_idx,
    output logic       o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!o_found && (i >= 32'(i_start)) && i_mask[i]) begin
                o_found = 1'b1;
                o_idx   = i[1:0];
            end
        end
    end

endmodule

// File: rtl/mux4a1_serializer.sv
// mux4a1_serializer
//   Re-serializes a group of four parallel byte lanes onto one lane at one
//   byte per cclk, in lane order 0..3.
//   Ports:
//     cclk                   clock, rising edge
//     reset_L                synchronous reset, active low
//     valid_in0..3           per-lane valid of the offered group
//     data_in0..3 [DATA_W]   per-lane data
//     in_ready               a group offered now is accepted at the next edge
//     valid_out              serialized byte valid (registered)
//     data_out   [DATA_W]    serialized byte (registered)
//     slot_out   [1:0]       source lane of data_out (registered)
//     err_drop               sticky: a group was offered while in_ready was low
//   Macro MUX_SKIP_INVALID_EN: when defined, invalid lanes are skipped rather
//   than emitted as bubbles in fixed 4-slot frames.
module mux4a1_serializer
    import mux4a1_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              cclk,
    input  logic              reset_L,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic              in_ready,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        slot_out,
    output logic              err_drop
);

    logic [3:0]        w_vin;
    logic [DATA_W-1:0] w_din [LANES];

    state_t            r_state, w_state_nx;
    logic [1:0]        r_slot, w_slot_nx;
    logic [3:0]        r_hold_v;
    logic [DATA_W-1:0] r_hold_d [LANES];
    logic              r_valid, w_valid_nx;
    logic [DATA_W-1:0] r_data, w_data_nx;
    logic [1:0]        r_sout, w_sout_nx;
    logic              r_err;

    logic              w_offer, w_more, w_last, w_accept;
    logic [1:0]        w_first, w_next;

    assign w_vin    = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign w_din[0] = data_in0;
    assign w_din[1] = data_in1;
    assign w_din[2] = data_in2;
    assign w_din[3] = data_in3;

`ifdef MUX_SKIP_INVALID_EN
    logic w_first_found, w_next_found;

    lane_pick4 u_pick_first (
        .i_mask  (w_vin),
        .i_start (2'd0),
        .o_idx   (w_first),
        .o_found (w_first_found)
    );

    // Search the held mask past the current slot; at slot 3 the start index
    // wraps, so the slot-3 test below overrides whatever is found.
    lane_pick4 u_pick_next (
        .i_mask  (r_hold_v),
        .i_start (r_slot + 2'd1),
        .o_idx   (w_next),
        .o_found (w_next_found)
    );

    assign w_offer = w_first_found;
    assign w_more  = w_next_found && (r_slot != 2'd3);
`else
    assign w_offer = |w_vin;
    assign w_first = 2'd0;
    assign w_next  = r_slot + 2'd1;
    assign w_more  = (r_slot != 2'd3);
`endif

    // in_ready depends only on state and slot, never on the inputs.
    assign w_last   = (r_state == ST_SEND) && !w_more;
    assign in_ready = (r_state == ST_IDLE) || w_last;
    assign w_accept = w_offer && in_ready;

    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_valid_nx = 1'b0;
        w_data_nx  = '0;
        w_sout_nx  = '0;
        if (w_accept) begin
            w_state_nx = ST_SEND;
            w_slot_nx  = w_first;
            w_valid_nx = w_vin[w_first];
            w_data_nx  = w_vin[w_first] ? w_din[w_first] : '0;
            w_sout_nx  = w_first;
        end else if (r_state == ST_SEND) begin
            if (w_last) begin
                w_state_nx = ST_IDLE;
                w_slot_nx  = '0;
            end else begin
                w_slot_nx  = w_next;
                w_valid_nx = r_hold_v[w_next];
                w_data_nx  = r_hold_v[w_next] ? r_hold_d[w_next] : '0;
                w_sout_nx  = w_next;
            end
        end
    end

    always_ff @(posedge cclk) begin
        if (!reset_L) begin
            r_state  <= ST_IDLE;
            r_slot   <= '0;
            r_hold_v <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_hold_d[i] <= '0;
            end
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sout   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_slot  <= w_slot_nx;
            r_valid <= w_valid_nx;
            r_data  <= w_data_nx;
            r_sout  <= w_sout_nx;
            r_err   <= r_err | (w_offer & ~in_ready);
            if (w_accept) begin
                r_hold_v <= w_vin;
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_hold_d[i] <= w_din[i];
                end
            end
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign slot_out  = r_sout;
    assign err_drop  = r_err;

endmodule

// File: tb/tb_mux4a1_serializer.sv
// tb_mux4a1_serializer
//   Self-checking bench for mux4a1_serializer. A queue-based reference model
//   expands each accepted group into its per-cycle output entries; the DUT
//   outputs are compared against the entry shown after every edge.
//   Honors MUX_SKIP_INVALID_EN the same way as the design.
module tb_mux4a1_serializer;

    logic       cclk = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
    logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
    logic       in_ready, valid_out, err_drop;
    logic [7:0] data_out;
    logic [1:0] slot_out;

    always #5 cclk = ~cclk;

    mux4a1_serializer #(.DATA_W(8)) dut (
        .cclk      (cclk),
        .reset_L   (reset_L),
        .valid_in0 (valid_in0),
        .valid_in1 (valid_in1),
        .valid_in2 (valid_in2),
        .valid_in3 (valid_in3),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .slot_out  (slot_out),
        .err_drop  (err_drop)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] s;
    } ent_t;

    ent_t q[$];
    ent_t cur = '0;
    logic m_err = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [12:0] model_exp();
        return {cur.v, cur.d, cur.s, (q.size() == 0), m_err};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic tick(input logic rst, input logic [3:0] vin,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e);
        logic [7:0] dd [4];
        logic       ready;
        dd[0] = a; dd[1] = b; dd[2] = c; dd[3] = e;
        reset_L = rst;
        {valid_in3, valid_in2, valid_in1, valid_in0} = vin;
        data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = e;
        @(posedge cclk);
        if (!rst) begin
            q.delete();
            cur   = '0;
            m_err = 1'b0;
        end else begin
            ready = (q.size() == 0);
            if (vin != 4'b0000) begin
                if (ready) begin
                    for (int k = 0; k < 4; k++) begin
`ifdef MUX_SKIP_INVALID_EN
                        if (vin[k]) q.push_back('{v: 1'b1, d: dd[k], s: 2'(k)});
`else
                        q.push_back('{v: vin[k], d: (vin[k] ? dd[k] : 8'h00), s: 2'(k)});
`endif
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (q.size() != 0) cur = q.pop_front();
            else               cur = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            tick((i >= 2), 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
    endtask

    task automatic test_full_group();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) tick(1'b1, 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
            else        tick(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL full_group cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
    endtask

    task automatic test_back_to_back();
        int run;
        run = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      tick(1'b1, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
            else if (i == 4) tick(1'b1, 4'b1111, 8'h20, 8'h21, 8'h22, 8'h23);
            else             tick(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            if (i < 8 && valid_out) run++;
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
        n_checks++;
        if (run != 8) begin
            n_fail++;
            $display("FAIL back_to_back_run: got %0d valid bytes exp 8", run);
        end
    endtask

    task automatic test_partial();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) tick(1'b1, 4'b1010, 8'h44, 8'h55, 8'h66, 8'h77);
            else        tick(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL partial cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      tick(1'b1, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
            else if (i == 1) tick(1'b1, 4'b1111, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
            else             tick(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL overrun cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
            if (i >= 1) begin
                n_checks++;
                if (err_drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_sticky cyc%0d: got %b exp 1", i, err_drop);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      tick(1'b1, 4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
            else if (i == 2) tick(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            else             tick(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] vin;
        logic       rst;
        for (int i = 0; i < 400; i++) begin
            vin = ($urandom_range(0, 9) < 5) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rst = ($urandom_range(0, 59) != 0);
            tick(rst, vin, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            n_checks++;
            if ({valid_out, data_out, slot_out, in_ready, err_drop} !== model_exp()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h exp %h", i,
                         {valid_out, data_out, slot_out, in_ready, err_drop}, model_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_back_to_back();
        test_partial();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
